// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and default widths
// shared by alu, rr_picker and alu_arbiter.
package alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_OPW   = 3;

  localparam logic [DEF_OPW-1:0] OP_ADD = 3'b000;
  localparam logic [DEF_OPW-1:0] OP_OR  = 3'b001;
  localparam logic [DEF_OPW-1:0] OP_SLL = 3'b010;
  localparam logic [DEF_OPW-1:0] OP_SRL = 3'b011;
  localparam logic [DEF_OPW-1:0] OP_SUB = 3'b100;
  localparam logic [DEF_OPW-1:0] OP_EQ  = 3'b101;
  localparam logic [DEF_OPW-1:0] OP_AND = 3'b110;
  localparam logic [DEF_OPW-1:0] OP_NOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// alu: combinational WIDTH-bit ALU with zero flag.
// OP_EQ yields rs^rt so zero=1 means the operands match.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;

  assign shamt = rt[SW-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = rs + rt;
      OP_OR:   result = rs | rt;
      OP_SLL:  result = rs << shamt;
      OP_SRL:  result = rs >> shamt;
      OP_SUB:  result = rs - rt;
      OP_EQ:   result = rs ^ rt;
      OP_AND:  result = rs & rt;
      OP_NOR:  result = ~(rs | rt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_picker.sv
// rr_picker: combinational grant select. ALU_ARBITER_RR_EN
// gives round-robin from last+1; otherwise lowest index wins.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
`ifdef ALU_ARBITER_RR_EN
  input  logic [LW-1:0]   last,
`endif
  output logic [NREQ-1:0] grant,
  output logic [LW-1:0]   idx,
  output logic            hit
);

  logic [LW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    k     = '0;
`ifdef ALU_ARBITER_RR_EN
    for (int i = 1; i <= NREQ; i++) begin
      k = LW'((int'(last) + i) % NREQ);
      if (!hit && valid[k]) begin
        hit      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      k = LW'(i);
      if (!hit && valid[k]) begin
        hit      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu among NREQ valid/ready clients.
// Define ALU_ARBITER_RR_EN for round-robin, else fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int NREQ  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_rs_i,
  input  logic [NREQ*WIDTH-1:0] req_rt_i,
  input  logic [NREQ*OPW-1:0]   req_op_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  input  logic [NREQ-1:0]   rsp_ready_i,
  output logic [WIDTH-1:0]  rsp_result_o,
  output logic              rsp_zero_o,
  output logic              busy_o
);

  localparam int LW = $clog2(NREQ);

  state_e state_q;
  state_e state_d;

  logic [NREQ-1:0]  grant;
  logic [LW-1:0]    win_idx;
  logic             win_hit;
  logic             accept;
  logic [LW-1:0]    owner_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;

`ifdef ALU_ARBITER_RR_EN
  logic [LW-1:0]    last_q;
`endif

  assign accept = (state_q == IDLE) && win_hit;

  rr_picker #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .valid (req_valid_i),
`ifdef ALU_ARBITER_RR_EN
    .last  (last_q),
`endif
    .grant (grant),
    .idx   (win_idx),
    .hit   (win_hit)
  );

`ifdef ALU_ARBITER_RR_EN
  // NREQ-1 so that requester 0 is first in line after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= LW'(NREQ - 1);
    end else if (accept) begin
      last_q <= win_idx;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_hit) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready_i[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is masked during reset so no transfer is implied
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    busy_o      = (state_q != IDLE);
    if (state_q == IDLE && !rst_i) begin
      req_ready_o = grant;
    end
    if (state_q == RESP) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs_q    <= '0;
      rt_q    <= '0;
      op_q    <= '0;
      owner_q <= '0;
    end else if (accept) begin
      rs_q    <= req_rs_i[win_idx*WIDTH +: WIDTH];
      rt_q    <= req_rt_i[win_idx*WIDTH +: WIDTH];
      op_q    <= req_op_i[win_idx*OPW +: OPW];
      owner_q <= win_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q  <= alu_res;
      zero_q <= alu_zero;
    end
  end

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .rs     (rs_q),
    .rt     (rt_q),
    .op     (op_q),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign rsp_result_o = res_q;
  assign rsp_zero_o   = zero_q;

endmodule
